input_debounce: RTL and testbench
=================================

Name: input_debounce

Overview:
- Input conditioning stage directly upstream of the glue logic. Synchronizes WIDTH asynchronous field inputs (e.g. in4..in7) into the clk domain and debounces each one independently.
- Delivers clean levels plus one-cycle rise/fall pulses to the glue logic inputs.
- Contains its own sample-tick prescaler, so no slow clock is needed.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- TICK_HZ, 1000, debounce sample rate in Hz. Constraint: CLK_HZ/TICK_HZ >= 2.
- DEBOUNCE_TICKS, 8, number of consecutive ticks with a stable mismatch required to accept a new level. Must be >= 1.
- WIDTH, 4, number of input channels.

Ports:
- clk  input  1  system clock, 50 MHz.
- reset_n  input  1  reset. Asynchronous, active-low.
- in_raw  input  WIDTH  asynchronous raw inputs (switches, contacts).
- db_out  output  WIDTH  debounced levels.
- rise  output  WIDTH  one-clk pulse when db_out bit goes 0->1.
- fall  output  WIDTH  one-clk pulse when db_out bit goes 1->0.
- tick  output  1  one-clk sample strobe, exported for debug/reuse.

Behaviour:
- Reset (reset_n=0, asynchronous): sync flops, prescaler, per-channel counters, db_out, rise, fall and tick all go to 0 immediately. They stay 0 until reset_n rises.
- Synchronizer: 2-FF chain per bit. sync[i] = in_raw[i] delayed 2 clk edges. No other path from in_raw to logic.
- Prescaler:
  - DIV = CLK_HZ/TICK_HZ (integer division). Counter width $clog2(DIV).
  - Counts 0..DIV-1 and wraps to 0.
  - tick = 1 for exactly the one cycle the counter equals DIV-1, so the first tick is DIV cycles after reset release.
  - Free-running; independent of inputs.
- Per-channel counter: cnt[i], width $clog2(DEBOUNCE_TICKS+1). Two states per channel, STABLE (cnt=0) and PENDING (cnt>0).
  - If sync[i] == db_out[i]: cnt[i] <= 0 on every clk, irrespective of tick. Any return to the old level aborts the pending change.
  - If sync[i] != db_out[i] and tick:
    - cnt[i] == DEBOUNCE_TICKS-1: db_out[i] <= sync[i], cnt[i] <= 0, and rise[i] or fall[i] = 1 for that same next cycle.
    - Otherwise cnt[i] <= cnt[i]+1.
  - If sync[i] != db_out[i] and no tick: hold cnt[i].
  - Net effect: a new level is accepted on the DEBOUNCE_TICKS-th tick at which the mismatch is still present. Acceptance latency after an in_raw edge is 2 clk + DEBOUNCE_TICKS ticks, minus up to one tick period (tick phase).
- rise/fall:
  - Registered; asserted in the same cycle db_out changes; deasserted the following cycle.
  - Never both set on one channel.
  - Never set without a db_out change.
- Channels are fully independent. Simultaneous changes on several channels may update in the same cycle.
- No saturation or overflow: cnt never exceeds DEBOUNCE_TICKS-1.
- Boundary cases:
  - Glitch that ends before DEBOUNCE_TICKS ticks have sampled it: rejected, no output activity.
  - Input toggling continuously: db_out holds its current value indefinitely.
  - Input changes exactly on a tick cycle: the sync value present at that tick is the one counted.
  - DEBOUNCE_TICKS=1: accept on the first tick that sees the mismatch.
  - Input held high through reset: db_out rises normally after the debounce time from reset release.

Test Plan (bench params CLK_HZ=1000, TICK_HZ=100 giving DIV=10, DEBOUNCE_TICKS=4, WIDTH=4):
1. Reset: reset_n low, in_raw=4'b0000, then release.
   - All outputs 0 while low.
   - First tick pulse at clk cycle 10 after release; subsequent ticks every 10 cycles.
2. Clean edge: in_raw[0] 0->1 at cycle 3 after reset release, held.
   - db_out=4'b0001 and rise=4'b0001 (one cycle) at the 4th tick, cycle 40.
   - fall stays 0.
   - Same test in reverse (1->0) produces a fall pulse instead.
3. Glitch: in_raw[1] high for 25 cycles, spanning 2-3 ticks, then low.
   - db_out[1], rise[1] and fall[1] stay 0 throughout.
4. Bounce: in_raw[2] toggles 0->1->0->1 at 7-cycle spacing, then stays 1.
   - db_out[2] rises exactly on the 4th tick after the final edge's synchronized arrival.
   - Exactly one rise pulse.
5. Simultaneous: in_raw 4'b0000 -> 4'b1111 in one cycle.
   - All four db_out bits and rise bits assert in the same cycle.
   - Then 4'b1111 -> 4'b0000 gives four simultaneous fall pulses.
6. Reset mid-operation: with in_raw[3]=1, assert reset_n after 2 of 4 ticks counted.
   - Outputs stay 0, no rise pulse.
   - After release, db_out[3] rises at the 4th tick counted from release.
   - With db_out=4'b1111, asserting reset_n forces db_out to 0 without waiting for a clk edge.

Source files
------------

// File: rtl/input_debounce.sv
// Synchronizes WIDTH asynchronous inputs and debounces each one against a shared sample tick.
// Provides clean levels plus one-cycle rise/fall pulses.
module input_debounce #(
   parameter int CLK_HZ         = 50000000,
   parameter int TICK_HZ        = 1000,
   parameter int DEBOUNCE_TICKS = 8,
   parameter int WIDTH          = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in_raw,
   output logic [WIDTH-1:0] db_out,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             tick
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int CW  = (DEBOUNCE_TICKS > 0) ? $clog2(DEBOUNCE_TICKS + 1) : 1;

   logic [WIDTH-1:0] sync_meta_reg;
   logic [WIDTH-1:0] sync_reg;
   logic [PW-1:0]    pre_cnt_reg;
   logic [PW-1:0]    pre_cnt_next;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_meta_reg <= '0;
         sync_reg      <= '0;
      end else begin
         sync_meta_reg <= in_raw;
         sync_reg      <= sync_meta_reg;
      end
   end

   // Free-running prescaler; tick is decoded from the terminal count, so it is 0 while in reset.
   assign tick = (pre_cnt_reg == PW'(DIV - 1));

   always_comb begin
      pre_cnt_next = pre_cnt_reg + PW'(1);
      if (tick) begin
         pre_cnt_next = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pre_cnt_reg <= '0;
      end else begin
         pre_cnt_reg <= pre_cnt_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_ch
         logic [CW-1:0] cnt_reg;
         logic [CW-1:0] cnt_next;
         logic          db_reg;
         logic          db_next;
         logic          rise_reg;
         logic          rise_next;
         logic          fall_reg;
         logic          fall_next;

         // cnt_reg == 0 is the stable state; any return to the accepted level aborts a pending change.
         always_comb begin
            cnt_next  = cnt_reg;
            db_next   = db_reg;
            rise_next = 1'b0;
            fall_next = 1'b0;
            if (sync_reg[gi] == db_reg) begin
               cnt_next = '0;
            end else if (tick) begin
               if (cnt_reg == CW'(DEBOUNCE_TICKS - 1)) begin
                  cnt_next  = '0;
                  db_next   = sync_reg[gi];
                  rise_next = sync_reg[gi];
                  fall_next = ~sync_reg[gi];
               end else begin
                  cnt_next = cnt_reg + CW'(1);
               end
            end
         end

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               cnt_reg  <= '0;
               db_reg   <= 1'b0;
               rise_reg <= 1'b0;
               fall_reg <= 1'b0;
            end else begin
               cnt_reg  <= cnt_next;
               db_reg   <= db_next;
               rise_reg <= rise_next;
               fall_reg <= fall_next;
            end
         end

         assign db_out[gi] = db_reg;
         assign rise[gi]   = rise_reg;
         assign fall[gi]   = fall_reg;
      end
   endgenerate

endmodule

// File: tb/tb_input_debounce.sv
// Self-checking bench for input_debounce: behavioural model compared every cycle,
// directed pins of key latencies, then randomized stimulus with bounces and resets.
`timescale 1ns/1ps
module tb_input_debounce;

   localparam int CLK_HZ  = 1000;
   localparam int TICK_HZ = 100;
   localparam int DT      = 4;
   localparam int W       = 4;
   localparam int DIV     = CLK_HZ / TICK_HZ;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [W-1:0] in_raw = '0;
   logic [W-1:0] db_out;
   logic [W-1:0] rise;
   logic [W-1:0] fall;
   logic         tick;

   int compared = 0;
   int mismatched = 0;

   input_debounce #(
      .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DEBOUNCE_TICKS(DT), .WIDTH(W)
   ) dut (
      .clk(clk), .reset_n(reset_n), .in_raw(in_raw),
      .db_out(db_out), .rise(rise), .fall(fall), .tick(tick)
   );

   always #5 clk = ~clk;

   // Model state: edges since reset release, 2-deep input history, accepted level,
   // and for each channel how many ticks in a row have seen the new level.
   int           n = 0;
   logic [W-1:0] hist0 = '0;
   logic [W-1:0] hist1 = '0;
   logic [W-1:0] m_db = '0;
   logic [W-1:0] m_rise = '0;
   logic [W-1:0] m_fall = '0;
   logic         m_tick = 1'b0;
   int           seen [W];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_step();
      logic [W-1:0] sampled;
      bit           t;
      if (!reset_n) begin
         n = 0; hist0 = '0; hist1 = '0; m_db = '0; m_rise = '0; m_fall = '0;
         for (int c = 0; c < W; c++) seen[c] = 0;
      end else begin
         t       = ((n % DIV) == DIV - 1);
         sampled = hist1;
         hist1   = hist0;
         hist0   = in_raw;
         m_rise  = '0;
         m_fall  = '0;
         for (int c = 0; c < W; c++) begin
            if (sampled[c] == m_db[c]) begin
               seen[c] = 0;
            end else if (t) begin
               seen[c] = seen[c] + 1;
               if (seen[c] == DT) begin
                  m_db[c] = sampled[c];
                  if (sampled[c]) m_rise[c] = 1'b1;
                  else m_fall[c] = 1'b1;
                  seen[c] = 0;
               end
            end
         end
         n = n + 1;
      end
      m_tick = reset_n && ((n % DIV) == DIV - 1);
   endtask

   initial begin
      for (int c = 0; c < W; c++) seen[c] = 0;
      forever begin
         @(posedge clk or negedge reset_n);
         model_step();
      end
   end

   bit run_cmp = 1'b0;
   initial begin
      forever begin
         @(negedge clk);
         if (run_cmp) begin
            check("db_out", 32'(db_out), 32'(m_db));
            check("rise", 32'(rise), 32'(m_rise));
            check("fall", 32'(fall), 32'(m_fall));
            check("tick", 32'(tick), 32'(m_tick));
         end
      end
   end

   task automatic do_reset(input int cycles);
      @(negedge clk);
      reset_n = 1'b0;
      repeat (cycles) @(negedge clk);
      reset_n = 1'b1;
   endtask

   int first_tick, second_tick, db0_n, rise0_cnt, fall0_cnt, act1;
   bit all_rise, all_fall;
   int db3_n;

   initial begin
      reset_n = 1'b0;
      in_raw  = '0;
      run_cmp = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_db", 32'(db_out), 32'd0);
      check("reset_tick", 32'(tick), 32'd0);
      reset_n = 1'b1;

      // Tick phase and clean rising edge on channel 0, driven after the 2nd edge.
      first_tick = -1; second_tick = -1; db0_n = -1; rise0_cnt = 0; fall0_cnt = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (n == 2) in_raw[0] = 1'b1;
         if (tick) begin
            if (first_tick < 0) first_tick = n;
            else if (second_tick < 0) second_tick = n;
         end
         if (db_out[0] && db0_n < 0) db0_n = n;
         rise0_cnt += int'(rise[0]);
         fall0_cnt += int'(fall[0]);
      end
      check("first_tick_edge", 32'(first_tick), 32'd9);
      check("second_tick_edge", 32'(second_tick), 32'd19);
      check("db0_accept_edge", 32'(db0_n), 32'd40);
      check("rise0_count", 32'(rise0_cnt), 32'd1);
      check("fall0_none", 32'(fall0_cnt), 32'd0);

      in_raw[0] = 1'b0;
      rise0_cnt = 0; fall0_cnt = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         rise0_cnt += int'(rise[0]);
         fall0_cnt += int'(fall[0]);
      end
      check("fall0_count", 32'(fall0_cnt), 32'd1);
      check("rise0_none", 32'(rise0_cnt), 32'd0);
      check("db0_low", 32'(db_out[0]), 32'd0);

      // 25-cycle glitch on channel 1 is seen by at most three ticks.
      act1 = 0;
      in_raw[1] = 1'b1;
      for (int k = 0; k < 70; k++) begin
         @(negedge clk);
         if (k == 24) in_raw[1] = 1'b0;
         act1 += int'(db_out[1] | rise[1] | fall[1]);
      end
      check("glitch1_quiet", 32'(act1), 32'd0);

      // All channels together.
      all_rise = 1'b0; all_fall = 1'b0;
      in_raw = 4'b1111;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (rise == 4'b1111) all_rise = 1'b1;
      end
      in_raw = 4'b0000;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (fall == 4'b1111) all_fall = 1'b1;
      end
      check("simul_rise", 32'(all_rise), 32'd1);
      check("simul_fall", 32'(all_fall), 32'd1);

      // Reset after two ticks of a pending change: counting restarts from release.
      do_reset(2);
      in_raw[3] = 1'b1;
      while (n < 25) @(negedge clk);
      do_reset(3);
      db3_n = -1;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (db_out[3] && db3_n < 0) db3_n = n;
      end
      check("db3_after_reset", 32'(db3_n), 32'd40);

      // Asynchronous reset clears outputs between clock edges.
      in_raw = 4'b1111;
      repeat (60) @(negedge clk);
      check("db_all_high", 32'(db_out), 32'hF);
      #2 reset_n = 1'b0;
      #1 check("async_reset_db", 32'(db_out), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Randomized holds, bounces and occasional resets.
      for (int seg = 0; seg < 120; seg++) begin
         int mode;
         mode = $urandom_range(0, 9);
         if (mode == 0) begin
            do_reset($urandom_range(1, 4));
         end else if (mode < 5) begin
            in_raw = W'($urandom);
            repeat ($urandom_range(1, 60)) @(negedge clk);
         end else begin
            int b;
            b = $urandom_range(0, W - 1);
            repeat ($urandom_range(2, 8)) begin
               in_raw[b] = ~in_raw[b];
               repeat ($urandom_range(1, 12)) @(negedge clk);
            end
         end
      end
      repeat (60) @(negedge clk);

      run_cmp = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
